// File: rtl/mmio_interval_timer.sv
// mmio_interval_timer: memory-mapped down-counting interval timer.
// Register map on a[1:0]: 0 CTRL {AUTO,EN}, 1 LOAD, 2 COUNT, 3 STATUS {RUN,DONE}.
// A prescaler divides clk into ticks; each tick decrements COUNT, and an
// expiry (tick seen with COUNT <= 1) sets the sticky DONE flag and either
// reloads COUNT (AUTO) or stops the timer (one-shot).
module mmio_interval_timer #(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       a,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd,
    output logic             irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LOAD   = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    typedef enum logic {IDLE, RUN} state_e;

    state_e            state_q, state_d;
    logic              en_q, en_d;
    logic              auto_q, auto_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  load_q, load_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [PW-1:0]     presc_q, presc_d;

    logic wr_ctrl, wr_load, wr_count, wr_status;
    logic tick, expiry, oneshot_expiry;

    assign wr_ctrl   = we && (a == A_CTRL);
    assign wr_load   = we && (a == A_LOAD);
    assign wr_count  = we && (a == A_COUNT);
    assign wr_status = we && (a == A_STATUS);

    // A tick that coincides with a COUNT write is consumed by the write,
    // so expiry is only evaluated on ticks that are not overridden.
    assign tick           = (state_q == RUN) && (presc_q == PRE_LAST);
    assign expiry         = tick && !wr_count && (count_q <= WIDTH'(1));
    assign oneshot_expiry = expiry && !auto_q;

    // Next-state logic for FSM, control bits, counters and DONE flag.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        en_d    = en_q;
        auto_d  = auto_q;
        done_d  = done_q;
        load_d  = load_q;
        count_d = count_q;
        presc_d = '0;

        // A CTRL write overrides a simultaneous one-shot stop.
        if (wr_ctrl) begin
            en_d    = wd[0];
            auto_d  = wd[1];
            state_d = wd[0] ? RUN : IDLE;
        end else if (oneshot_expiry) begin
            en_d    = 1'b0;
            state_d = IDLE;
        end

        if (wr_load) begin
            load_d = wd;
        end

        if (wr_count) begin
            count_d = wd;
        end else if (tick) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                count_d = auto_q ? load_q : '0;
            end
        end

        // Setting DONE takes priority over a software clear.
        if (expiry) begin
            done_d = 1'b1;
        end else if (wr_status && wd[0]) begin
            done_d = 1'b0;
        end

        // Prescaler runs only while staying in RUN; cleared on entry and in IDLE.
        if (state_q == RUN && state_d == RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from the pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= '0;
            count_q <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            auto_q  <= auto_d;
            done_q  <= done_d;
            load_q  <= load_d;
            count_q <= count_d;
            presc_q <= presc_d;
        end
    end

    // Zero-latency read mux selected by the register address.
    always_comb begin
        rd = '0;
        unique case (a)
            A_CTRL:   rd = {{(WIDTH-2){1'b0}}, auto_q, en_q};
            A_LOAD:   rd = load_q;
            A_COUNT:  rd = count_q;
            A_STATUS: rd = {{(WIDTH-2){1'b0}}, (state_q == RUN), done_q};
            default:  rd = '0;
        endcase
    end

    assign irq = done_q;

endmodule

// File: tb/tb_mmio_interval_timer.sv
// Directed testbench for mmio_interval_timer with PRESCALE=4.
// Stimulus is driven and outputs sampled on the falling clock edge; a bus
// write presented at one falling edge lands on the following rising edge.
module tb_mmio_interval_timer;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             we;
    logic [1:0]       a;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;
    logic             irq;

    int n_cmp = 0;
    int n_mis = 0;

    mmio_interval_timer #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .a   (a),
        .wd  (wd),
        .rd  (rd),
        .irq (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; the write lands on the next rising edge and
    // the task returns at the falling edge after it.
    task automatic bus_write(input logic [1:0] addr, input logic [WIDTH-1:0] data);
        we = 1'b1;
        a  = addr;
        wd = data;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [WIDTH-1:0] val);
        a = addr;
        #1;
        val = rd;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] v;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i), v);
            n_cmp++;
            if (v !== '0) begin
                n_mis++;
                $display("FAIL reset_rd_a%0d: got %0h expected 0", i, v);
            end
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_oneshot();
        logic [WIDTH-1:0] v;
        do_reset();
        bus_write(2'd1, 32'd3);
        bus_write(2'd2, 32'd3);
        bus_write(2'd0, 32'd1);   // entry to RUN, t=0
        wait_cyc(3);              // t=3, no tick yet
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd3) begin n_mis++; $display("FAIL oneshot_count_t3: got %0d expected 3", v); end
        bus_read(2'd3, v);
        n_cmp++;
        if (v !== 32'd2) begin n_mis++; $display("FAIL oneshot_status_run: got %0h expected 2", v); end
        wait_cyc(1);              // t=4
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd2) begin n_mis++; $display("FAIL oneshot_count_t4: got %0d expected 2", v); end
        wait_cyc(4);              // t=8
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd1) begin n_mis++; $display("FAIL oneshot_count_t8: got %0d expected 1", v); end
        n_cmp++;
        if (irq !== 1'b0) begin n_mis++; $display("FAIL oneshot_irq_t8: got %b expected 0", irq); end
        wait_cyc(4);              // t=12, expiry
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd0) begin n_mis++; $display("FAIL oneshot_count_t12: got %0d expected 0", v); end
        n_cmp++;
        if (irq !== 1'b1) begin n_mis++; $display("FAIL oneshot_irq_t12: got %b expected 1", irq); end
        bus_read(2'd0, v);
        n_cmp++;
        if (v !== 32'd0) begin n_mis++; $display("FAIL oneshot_ctrl_t12: got %0h expected 0", v); end
        bus_read(2'd3, v);
        n_cmp++;
        if (v !== 32'd1) begin n_mis++; $display("FAIL oneshot_status_t12: got %0h expected 1", v); end
        wait_cyc(8);              // stays stopped at 0
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd0) begin n_mis++; $display("FAIL oneshot_count_hold: got %0d expected 0", v); end
    endtask

    // Continues into the collision scenario on the same auto-reload run.
    task automatic test_auto_reload_and_collision();
        logic [WIDTH-1:0] v;
        do_reset();
        bus_write(2'd1, 32'd2);
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'd3);   // t=0
        bus_read(2'd0, v);
        n_cmp++;
        if (v !== 32'd3) begin n_mis++; $display("FAIL auto_ctrl: got %0h expected 3", v); end
        wait_cyc(4);              // t=4
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd1) begin n_mis++; $display("FAIL auto_count_t4: got %0d expected 1", v); end
        n_cmp++;
        if (irq !== 1'b0) begin n_mis++; $display("FAIL auto_irq_t4: got %b expected 0", irq); end
        wait_cyc(4);              // t=8, expiry and reload
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd2) begin n_mis++; $display("FAIL auto_count_t8: got %0d expected 2", v); end
        bus_read(2'd3, v);
        n_cmp++;
        if (v !== 32'd3) begin n_mis++; $display("FAIL auto_status_t8: got %0h expected 3", v); end
        bus_write(2'd3, 32'd1);   // clear DONE, t=9
        n_cmp++;
        if (irq !== 1'b0) begin n_mis++; $display("FAIL auto_irq_cleared: got %b expected 0", irq); end
        bus_read(2'd3, v);
        n_cmp++;
        if (v !== 32'd2) begin n_mis++; $display("FAIL auto_status_cleared: got %0h expected 2", v); end
        wait_cyc(6);              // t=15
        n_cmp++;
        if (irq !== 1'b0) begin n_mis++; $display("FAIL auto_irq_t15: got %b expected 0", irq); end
        wait_cyc(1);              // t=16, second expiry
        n_cmp++;
        if (irq !== 1'b1) begin n_mis++; $display("FAIL auto_irq_t16: got %b expected 1", irq); end
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd2) begin n_mis++; $display("FAIL auto_count_t16: got %0d expected 2", v); end
        // Clear now, then schedule another clear exactly on the expiry at t=24.
        wait_cyc(1);              // t=17
        bus_write(2'd3, 32'd1);   // t=18
        n_cmp++;
        if (irq !== 1'b0) begin n_mis++; $display("FAIL coll_irq_precleared: got %b expected 0", irq); end
        wait_cyc(5);              // t=23
        bus_write(2'd3, 32'd1);   // lands on expiry edge, t=24
        n_cmp++;
        if (irq !== 1'b1) begin n_mis++; $display("FAIL coll_done_set_wins: got %b expected 1", irq); end
        // COUNT=7 written on the tick edge at t=28.
        wait_cyc(3);              // t=27
        bus_write(2'd2, 32'd7);   // t=28
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd7) begin n_mis++; $display("FAIL coll_count_write_wins: got %0d expected 7", v); end
        wait_cyc(4);              // t=32, next tick
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd6) begin n_mis++; $display("FAIL coll_count_after: got %0d expected 6", v); end
    endtask

    task automatic test_stop_restart();
        logic [WIDTH-1:0] v;
        do_reset();
        bus_write(2'd1, 32'd9);
        bus_write(2'd2, 32'd6);
        bus_write(2'd0, 32'd1);   // t=0
        wait_cyc(4);              // t=4
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd5) begin n_mis++; $display("FAIL stop_count_t4: got %0d expected 5", v); end
        wait_cyc(1);
        bus_write(2'd0, 32'd0);   // stop mid-prescale, t=6
        bus_read(2'd3, v);
        n_cmp++;
        if (v !== 32'd0) begin n_mis++; $display("FAIL stop_status: got %0h expected 0", v); end
        wait_cyc(10);             // t=16
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd5) begin n_mis++; $display("FAIL stop_count_hold: got %0d expected 5", v); end
        bus_write(2'd0, 32'd1);   // re-entry to RUN, e=0
        wait_cyc(3);              // e=3
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd5) begin n_mis++; $display("FAIL restart_count_e3: got %0d expected 5", v); end
        wait_cyc(1);              // e=4
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd4) begin n_mis++; $display("FAIL restart_count_e4: got %0d expected 4", v); end
        // EN=1 rewrite while running must not restart the prescaler.
        wait_cyc(1);
        bus_write(2'd0, 32'd1);   // e=6
        wait_cyc(1);              // e=7
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd4) begin n_mis++; $display("FAIL rewrite_count_e7: got %0d expected 4", v); end
        wait_cyc(1);              // e=8
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd3) begin n_mis++; $display("FAIL rewrite_count_e8: got %0d expected 3", v); end
    endtask

    task automatic test_load_zero();
        logic [WIDTH-1:0] v;
        do_reset();
        bus_write(2'd0, 32'd3);   // LOAD=0, COUNT=0, auto; t=0
        wait_cyc(4);              // t=4, expiry every tick
        n_cmp++;
        if (irq !== 1'b1) begin n_mis++; $display("FAIL load0_irq_t4: got %b expected 1", irq); end
        bus_write(2'd3, 32'd1);   // t=5
        wait_cyc(2);              // t=7
        n_cmp++;
        if (irq !== 1'b0) begin n_mis++; $display("FAIL load0_irq_t7: got %b expected 0", irq); end
        wait_cyc(1);              // t=8
        n_cmp++;
        if (irq !== 1'b1) begin n_mis++; $display("FAIL load0_irq_t8: got %b expected 1", irq); end
        bus_read(2'd2, v);
        n_cmp++;
        if (v !== 32'd0) begin n_mis++; $display("FAIL load0_count: got %0d expected 0", v); end
    endtask

    task automatic test_reset_midcount();
        logic [WIDTH-1:0] v;
        do_reset();
        bus_write(2'd1, 32'd5);
        bus_write(2'd2, 32'd1);
        bus_write(2'd0, 32'd1);   // t=0, expiry would land at t=4
        wait_cyc(3);              // t=3
        rst = 1'b1;
        wait_cyc(1);              // reset on the would-be tick edge
        rst = 1'b0;
        n_cmp++;
        if (irq !== 1'b0) begin n_mis++; $display("FAIL rstmid_irq: got %b expected 0", irq); end
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i), v);
            n_cmp++;
            if (v !== '0) begin n_mis++; $display("FAIL rstmid_rd_a%0d: got %0h expected 0", i, v); end
        end
        wait_cyc(8);
        n_cmp++;
        if (irq !== 1'b0) begin n_mis++; $display("FAIL rstmid_irq_later: got %b expected 0", irq); end
    endtask

    initial begin
        rst = 1'b1;
        we  = 1'b0;
        a   = 2'd0;
        wd  = '0;
        @(negedge clk);
        test_reset();
        test_oneshot();
        test_auto_reload_and_collision();
        test_stop_restart();
        test_load_zero();
        test_reset_midcount();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
